// File: rtl/dp_memory_tester.sv
// dp_memory_tester
// Traffic generator for the dual-port SRAM arbiter. It writes a selectable
// pattern to every location through port 1, reads each location back
// through port 2 and reports pass/fail, the mismatch count and the first
// failing address. Every output is a flop, so the arbiter never sees a glitch.
module dp_memory_tester #(
    parameter int ACCESS_CYCLES = 6,
    parameter int ADDR_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] a1,
    output logic [7:0]        din1,
    output logic              we1_n,
    output logic              oe1_n,
    output logic [ADDR_W-1:0] a2,
    output logic              we2_n,
    output logic              oe2_n,
    input  logic [7:0]        dout2
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HOLD,
        WR_RECOVER,
        RD_HOLD,
        FINISH
    } state_t;

    localparam int                HOLD_W    = $clog2(ACCESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCESS_CYCLES - 1);
    // Patterns index address bits up to bit 9; narrower sweeps zero-extend.
    localparam int                PW        = (ADDR_W < 10) ? 10 : ADDR_W;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt, addr_inc;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [1:0]          sel, sel_nxt;
    logic                busy_nxt, done_nxt, pass_nxt;
    logic [ADDR_W:0]     err_nxt;
    logic [ADDR_W-1:0]   first_nxt, a1_nxt, a2_nxt;
    logic [7:0]          din1_nxt;
    logic                we1_n_nxt, oe2_n_nxt;
    logic                addr_is_max;

    // Data written to (and expected back from) a given address.
    function automatic logic [7:0] pattern_of(input logic [1:0] s,
                                              input logic [ADDR_W-1:0] a);
        logic [PW-1:0] ax;
        ax = PW'(a);
        case (s)
            2'd0:    return ax[7:0];
            2'd1:    return ~ax[7:0];
            2'd2:    return ax[0] ? 8'hAA : 8'h55;
            default: return ax[9:2] ^ 8'hA5;
        endcase
    endfunction

    assign addr_inc    = addr + ADDR_W'(1);
    assign addr_is_max = (addr == {ADDR_W{1'b1}});

    // Next-state and next-output logic; strobes default to inactive.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        addr_nxt  = addr;
        hold_nxt  = hold_cnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
        err_nxt   = err_count;
        first_nxt = first_err_addr;
        a1_nxt    = a1;
        din1_nxt  = din1;
        we1_n_nxt = 1'b1;
        a2_nxt    = a2;
        oe2_n_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    sel_nxt   = pattern_sel;
                    err_nxt   = '0;
                    first_nxt = '0;
                    pass_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    addr_nxt  = '0;
                    hold_nxt  = '0;
                    a1_nxt    = '0;
                    din1_nxt  = pattern_of(pattern_sel, '0);
                    we1_n_nxt = 1'b0;
                    state_nxt = WR_HOLD;
                end
            end

            WR_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = WR_RECOVER;
                end else begin
                    hold_nxt  = hold_cnt + HOLD_W'(1);
                    we1_n_nxt = 1'b0;
                end
            end

            WR_RECOVER: begin
                hold_nxt = '0;
                if (addr_is_max) begin
                    addr_nxt  = '0;
                    a2_nxt    = '0;
                    oe2_n_nxt = 1'b0;
                    state_nxt = RD_HOLD;
                end else begin
                    addr_nxt  = addr_inc;
                    a1_nxt    = addr_inc;
                    din1_nxt  = pattern_of(sel, addr_inc);
                    we1_n_nxt = 1'b0;
                    state_nxt = WR_HOLD;
                end
            end

            RD_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    // Last hold clock: the arbiter's read register is settled.
                    hold_nxt = '0;
                    if (dout2 != pattern_of(sel, addr)) begin
                        err_nxt = err_count + (ADDR_W + 1)'(1);
                        if (err_count == '0) begin
                            first_nxt = addr;
                        end
                    end
                    if (addr_is_max) begin
                        state_nxt = FINISH;
                    end else begin
                        addr_nxt  = addr_inc;
                        a2_nxt    = addr_inc;
                        oe2_n_nxt = 1'b0;
                    end
                end else begin
                    hold_nxt  = hold_cnt + HOLD_W'(1);
                    oe2_n_nxt = 1'b0;
                end
            end

            FINISH: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = (err_count == '0);
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            hold_cnt       <= '0;
            sel            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            a1             <= '0;
            din1           <= '0;
            we1_n          <= 1'b1;
            oe1_n          <= 1'b1;
            a2             <= '0;
            we2_n          <= 1'b1;
            oe2_n          <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state          <= state_nxt;
            addr           <= addr_nxt;
            hold_cnt       <= hold_nxt;
            sel            <= sel_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            first_err_addr <= first_nxt;
            a1             <= a1_nxt;
            din1           <= din1_nxt;
            we1_n          <= we1_n_nxt;
            oe1_n          <= 1'b1;
            a2             <= a2_nxt;
            we2_n          <= 1'b1;
            oe2_n          <= oe2_n_nxt;
        end
    end

endmodule

// File: tb/tb_dp_memory_tester.sv
// Bench for dp_memory_tester: two instances (default size, and a short
// sweep at the minimum hold of 5) each drive a behavioural 4-phase arbiter
// with a read register and an SRAM array that can pin bit 3 at chosen
// addresses. Expected results come from the pattern rules applied to
// every address.
module tb_dp_memory_tester;

    localparam int AC0 = 6;
    localparam int AC1 = 5;
    localparam int N0  = 1024;
    localparam int N1  = 64;

    localparam logic [55:0] RST0 = {1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 10'd0, 8'd0,
                                    1'b1, 1'b1, 10'd0, 1'b1, 1'b1};
    localparam logic [39:0] RST1 = {1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0, 8'd0,
                                    1'b1, 1'b1, 6'd0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #18 clk = ~clk;

    // Per-instance views used by the generic tasks and monitors.
    logic        start_v [2];
    logic [1:0]  sel_v   [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        pass_v  [2];
    logic [10:0] errc_v  [2];
    logic [9:0]  ferr_v  [2];
    logic        we1n_v  [2];
    logic        oe1n_v  [2];
    logic        we2n_v  [2];
    logic        oe2n_v  [2];

    logic        busy0, done0, pass0, we1n0, oe1n0, we2n0, oe2n0;
    logic [10:0] errc0;
    logic [9:0]  ferr0, a1_0, a2_0;
    logic [7:0]  din1_0;
    wire  [7:0]  dout2_0;

    logic        busy1, done1, pass1, we1n1, oe1n1, we2n1, oe2n1;
    logic [6:0]  errc1;
    logic [5:0]  ferr1, a1_1, a2_1;
    logic [7:0]  din1_1;
    wire  [7:0]  dout2_1;

    dp_memory_tester #(.ACCESS_CYCLES(AC0), .ADDR_W(10)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .pattern_sel(sel_v[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0),
        .first_err_addr(ferr0), .a1(a1_0), .din1(din1_0), .we1_n(we1n0),
        .oe1_n(oe1n0), .a2(a2_0), .we2_n(we2n0), .oe2_n(oe2n0), .dout2(dout2_0)
    );

    dp_memory_tester #(.ACCESS_CYCLES(AC1), .ADDR_W(6)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .pattern_sel(sel_v[1]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1),
        .first_err_addr(ferr1), .a1(a1_1), .din1(din1_1), .we1_n(we1n1),
        .oe1_n(oe1n1), .a2(a2_1), .we2_n(we2n1), .oe2_n(oe2n1), .dout2(dout2_1)
    );

    assign busy_v[0] = busy0;  assign busy_v[1] = busy1;
    assign done_v[0] = done0;  assign done_v[1] = done1;
    assign pass_v[0] = pass0;  assign pass_v[1] = pass1;
    assign errc_v[0] = errc0;  assign errc_v[1] = 11'(errc1);
    assign ferr_v[0] = ferr0;  assign ferr_v[1] = 10'(ferr1);
    assign we1n_v[0] = we1n0;  assign we1n_v[1] = we1n1;
    assign oe1n_v[0] = oe1n0;  assign oe1n_v[1] = oe1n1;
    assign we2n_v[0] = we2n0;  assign we2n_v[1] = we2n1;
    assign oe2n_v[0] = oe2n0;  assign oe2n_v[1] = oe2n1;

    // Arbiter + SRAM: phase 0 serves the port-1 write, phase 2 loads the
    // port-2 read register; a faulty cell returns bit 3 pinned to fv.
    logic [1:0] phase = 2'd0;
    logic [7:0] mem0 [N0];
    logic [7:0] mem1 [N1];
    logic [7:0] rr0, rr1;
    bit         flt0 [N0];
    bit         flt1 [N1];
    bit         fv0, fv1;

    function automatic logic [7:0] faulty(input logic [7:0] d, input bit f, input bit v);
        logic [7:0] r;
        r = d;
        if (f) r[3] = v;
        return r;
    endfunction

    always @(posedge clk) begin
        phase <= phase + 2'd1;
        if (phase == 2'd0 && we1n0 == 1'b0) mem0[a1_0] <= din1_0;
        if (phase == 2'd0 && we1n1 == 1'b0) mem1[a1_1] <= din1_1;
        if (phase == 2'd2 && oe2n0 == 1'b0) rr0 <= faulty(mem0[a2_0], flt0[a2_0], fv0);
        if (phase == 2'd2 && oe2n1 == 1'b0) rr1 <= faulty(mem1[a2_1], flt1[a2_1], fv1);
    end

    assign dout2_0 = (oe2n0 == 1'b0) ? rr0 : 8'hzz;
    assign dout2_1 = (oe2n1 == 1'b0) ? rr1 : 8'hzz;

    // Port monitors: static strobes, read enable only after all writes,
    // and the width of every completed write pulse.
    int   run_len    [2] = '{0, 0};
    int   pulses_v   [2] = '{0, 0};
    int   strobe_bad [2] = '{0, 0};
    int   pulse_bad  [2] = '{0, 0};
    logic busy_prev  [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i] === 1'b1 && busy_prev[i] !== 1'b1) pulses_v[i] = 0;
            busy_prev[i] = busy_v[i];
            if (oe1n_v[i] !== 1'b1 || we2n_v[i] !== 1'b1) strobe_bad[i]++;
            if (oe2n_v[i] === 1'b0 && pulses_v[i] != ((i == 1) ? N1 : N0)) strobe_bad[i]++;
            if (rst) begin
                run_len[i] = 0;
            end else if (we1n_v[i] === 1'b0) begin
                run_len[i]++;
            end else if (run_len[i] > 0) begin
                pulses_v[i]++;
                if (run_len[i] != ((i == 1) ? AC1 : AC0)) pulse_bad[i]++;
                run_len[i] = 0;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pattern rules in plain arithmetic on the address value.
    function automatic int ref_pattern(input int s, input int a);
        case (s)
            0:       return a % 256;
            1:       return 255 - (a % 256);
            2:       return (a % 2 == 1) ? 170 : 85;
            default: return ((a / 4) % 256) ^ 165;
        endcase
    endfunction

    task automatic model_result(input int inst, input int s, output int n_err, output int first);
        int n;
        n     = (inst == 1) ? N1 : N0;
        n_err = 0;
        first = 0;
        for (int a = 0; a < n; a++) begin
            int good, seen;
            bit f, v;
            good = ref_pattern(s, a);
            f    = (inst == 1) ? flt1[6'(a)] : flt0[10'(a)];
            v    = (inst == 1) ? fv1 : fv0;
            seen = f ? (v ? (good | 8) : (good & 247)) : good;
            if (seen != good) begin
                if (n_err == 0) first = a;
                n_err++;
            end
        end
    endtask

    function automatic logic [55:0] pack0();
        return {busy0, done0, pass0, errc0, ferr0, a1_0, din1_0,
                we1n0, oe1n0, a2_0, we2n0, oe2n0};
    endfunction

    function automatic logic [39:0] pack1();
        return {busy1, done1, pass1, errc1, ferr1, a1_1, din1_1,
                we1n1, oe1n1, a2_1, we2n1, oe2n1};
    endfunction

    // One full run; called #1 after a clock edge, returns #1 after one.
    task automatic run_test(input int inst, input logic [1:0] s, input bit poke,
                            input string tag, output int exp_err);
        int n, ac, cycles, limit, exp_first;
        n     = (inst == 1) ? N1 : N0;
        ac    = (inst == 1) ? AC1 : AC0;
        limit = 2 * n * (2 * ac + 1) + 100;
        model_result(inst, int'(s), exp_err, exp_first);
        sel_v[inst]   = s;
        start_v[inst] = 1'b1;
        cycles        = 0;
        while (cycles < limit) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) begin
                start_v[inst] = 1'b0;
                check({tag, ".busy"}, 64'(busy_v[inst]), 64'd1);
            end
            if (poke && cycles == 300) begin
                sel_v[inst]   = 2'd3;
                start_v[inst] = 1'b1;
            end
            if (poke && cycles == 301) begin
                sel_v[inst]   = s;
                start_v[inst] = 1'b0;
            end
            if (done_v[inst] === 1'b1) break;
        end
        check({tag, ".cycles"}, 64'(cycles), 64'(n * (2 * ac + 1) + 2));
        check({tag, ".done"}, 64'(done_v[inst]), 64'd1);
        check({tag, ".pass"}, 64'(pass_v[inst]), 64'(exp_err == 0));
        check({tag, ".err_count"}, 64'(errc_v[inst]), 64'(exp_err));
        check({tag, ".first_err"}, 64'(ferr_v[inst]), 64'(exp_first));
        check({tag, ".wr_pulses"}, 64'(pulses_v[inst]), 64'(n));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 64'({done_v[inst], busy_v[inst]}), 64'd0);
    endtask

    initial begin
        int exp_err, ra, guard, nf;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        sel_v[0]   = 2'd0;
        sel_v[1]   = 2'd0;
        fv0 = 1'b0;
        fv1 = 1'b0;
        for (int a = 0; a < N0; a++) flt0[a] = 1'b0;
        for (int a = 0; a < N1; a++) flt1[a] = 1'b0;

        #5 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.outputs0", 64'(pack0()), 64'(RST0));
        check("rst.outputs1", 64'(pack1()), 64'(RST1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst.idle0", 64'(pack0()), 64'(RST0));

        // Bit 3 pinned low: pattern 1 stores bit 3 = 1 at both cells.
        flt0[10'h012] = 1'b1;
        flt0[10'h200] = 1'b1;
        fv0 = 1'b0;
        run_test(0, 2'd1, 1'b1, "fault_p1", exp_err);
        repeat (5) @(posedge clk);
        #1;
        check("fault_p1.hold", 64'({pass0, errc0, ferr0}), 64'({1'b0, 11'(exp_err), 10'h012}));

        flt0[10'h012] = 1'b0;
        flt0[10'h200] = 1'b0;
        run_test(0, 2'd2, 1'b0, "clean_p2", exp_err);
        check("clean_p2.mem001", 64'(mem0[10'h001]), 64'h0AA);
        check("clean_p2.mem000", 64'(mem0[10'h000]), 64'h055);

        // Abort mid-write; reset must act without a clock edge.
        sel_v[0]   = 2'd0;
        start_v[0] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
        end
        check("abort.busy", 64'(busy0), 64'd1);
        #4 rst = 1'b1;
        #1;
        check("abort.async", 64'(pack0()), 64'(RST0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort.idle", 64'(pack0()), 64'(RST0));

        run_test(0, 2'd0, 1'b0, "clean_p0", exp_err);
        check("clean_p0.mem3ff", 64'(mem0[10'h3FF]), 64'h0FF);
        check("clean_p0.mem155", 64'(mem0[10'h155]), 64'h055);
        ra = int'($urandom_range(0, N0 - 1));
        check("clean_p0.mem_rand", 64'(mem0[10'(ra)]), 64'(ref_pattern(0, ra)));

        // Minimum hold, start launched at each arbiter phase.
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            do begin
                @(posedge clk);
                #1;
                guard++;
            end while (phase != 2'(k) && guard < 8);
            run_test(1, 2'($urandom_range(0, 3)), 1'b0, "min_hold", exp_err);
        end

        // Random faults on the short sweep.
        nf  = int'($urandom_range(1, 4));
        fv1 = 1'($urandom_range(0, 1));
        for (int j = 0; j < nf; j++) flt1[6'($urandom_range(0, N1 - 1))] = 1'b1;
        run_test(1, 2'($urandom_range(0, 3)), 1'b0, "rand_fault", exp_err);
        ra = int'($urandom_range(0, N1 - 1));
        check("rand_fault.mem_rand", 64'(mem1[6'(ra)]), 64'(ref_pattern(int'(sel_v[1]), ra)));

        check("ports0.strobes", 64'(strobe_bad[0]), 64'd0);
        check("ports1.strobes", 64'(strobe_bad[1]), 64'd0);
        check("ports0.we1_width", 64'(pulse_bad[0]), 64'd0);
        check("ports1.we1_width", 64'(pulse_bad[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
